lsu_ctrl: RTL
=============

LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 16, REQ-state cycles without i_bus_ack before the access is aborted (range 2..255).
REQ-002 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 i_rst  input  1  asynchronous, active-high reset.
REQ-004 i_valid  input  1  execute-stage result valid this cycle.
REQ-005 i_control_signal  input  control_mem_s  .mem selects access; .iop=1 store, 0 load; .fcs_opcode size/sign; .rd destination.
REQ-006 i_addr  input  XLEN  effective address (execute rd output).
REQ-007 i_wdata  input  XLEN  store data (rs2).
REQ-008 o_bus_req, o_bus_we  output  1 each  bus request, write enable.
REQ-009 o_bus_addr  output  XLEN  word-aligned address (bits [1:0]=0).
REQ-010 o_bus_wdata  output  XLEN; o_bus_be  output  4  lane-steered write data, byte enables.
REQ-011 i_bus_ack  input  1; i_bus_rdata  input  XLEN  completion, read word (valid with ack).
REQ-012 o_stall  output  1  hold upstream pipeline.
REQ-013 o_wb_valid  output  1; o_wb_rd  output  5; o_wb_data  output  XLEN  load writeback.
REQ-014 o_fault  output  1; o_fault_cause  output  2  one-cycle fault pulse: 01 misaligned, 10 illegal opcode, 11 bus timeout.

Function
REQ-015 FSM states IDLE, REQ, DONE; only IDLE accepts new access.
REQ-016 IDLE, i_valid&&.mem: legal+aligned -> latch addr/data/opcode/rd/iop, go REQ; o_stall=1 combinationally that cycle.
REQ-017 Opcodes: 000 B, 001 H, 010 W, 100 BU, 101 HU; 011/11x, or BU/HU with iop=1, -> illegal.
REQ-018 Misaligned: H/HU with addr[0]=1; W with addr[1:0]!=0.
REQ-019 Illegal/misaligned in IDLE -> o_fault pulse that cycle with cause, no bus activity, stay IDLE, o_stall=0; illegal takes priority over misaligned.
REQ-020 REQ: o_bus_req=1, o_stall=1; addr/we/wdata/be held stable until ack cycle inclusive.
REQ-021 i_bus_ack in any REQ cycle (incl. first) -> DONE next cycle; ack outside REQ ignored.
REQ-022 Timeout counter clears on REQ entry, increments per REQ cycle without ack; at TIMEOUT_CYCLES -> o_fault cause 11 (one cycle), req dropped, go IDLE, no writeback; ack on the same cycle as expiry wins.
REQ-023 Stores: be = B 0001<<addr[1:0], H 0011<<addr[1:0], W 1111; wdata byte replicated x4, half x2, word as-is.
REQ-024 Loads: o_bus_we=0, o_bus_be=1111; lane shift by 8*addr[1:0], B/H sign-extended, BU/HU zero-extended, captured on ack.
REQ-025 DONE: o_stall=0; loads -> o_wb_valid=1 with data and rd for exactly that cycle; stores -> o_wb_valid=0; return IDLE.
REQ-026 rd=0 loads perform bus access but o_wb_valid=0.
REQ-027 Latency, ack in first REQ cycle: accept N, req N+1, writeback N+2.
REQ-028 i_valid with .mem=0 -> ignored, no stall.

Reset
REQ-029 i_rst asserted -> IDLE, counter 0, all outputs 0 immediately (incl. mid-REQ), no writeback of the aborted access.
REQ-030 First acceptance possible first rising edge after i_rst deasserts.

Structure
REQ-031 rapid_pkg holds lsu_state_e, size constants (LSU_B/H/W/BU/HU), fault-cause enum; control_mem_s unchanged.
REQ-032 One combinational sub-module lsu_lane_align: store lane steering/be and load extraction/extension; FSM and counter in lsu_ctrl.

Verification
REQ-033 SW 0x1000, data 0xDEADBEEF, ack first REQ cycle -> addr 0x1000, be 1111, wdata 0xDEADBEEF, stall 2 cycles, no wb.
REQ-034 LB 0x2003, rdata 0x80112233, ack after 3 cycles -> wb data 0xFFFFFF80, rd as issued, stall 5 cycles.
REQ-035 LHU 0x2002, rdata 0xBEEF0000 -> 0x0000BEEF; SH 0x2002 data 0x1234 -> be 1100, wdata 0x12341234.
REQ-036 LW 0x3001 -> fault cause 01 same cycle, no bus_req; opcode 011 -> cause 10.
REQ-037 No ack, TIMEOUT_CYCLES=4 -> req 4 cycles, cause 11 pulse, IDLE, next access accepted normally.
REQ-038 i_rst during REQ -> bus_req and stall 0 same cycle, later ack ignored, no writeback.

Source files
------------

// File: rtl/rapid_pkg.sv
// Shared types for the load/store unit: memory control bundle, FSM states,
// access size encodings and fault causes, plus opcode decode helpers.
package rapid_pkg;

    localparam int XLEN = 32;

    // Memory-stage control bundle handed over by execute.
    typedef struct packed {
        logic       mem;         // this instruction accesses memory
        logic       iop;         // 1 = store, 0 = load
        logic [2:0] fcs_opcode;  // access size / sign
        logic [4:0] rd;          // load destination register
    } control_mem_s;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_DONE = 2'd2
    } lsu_state_e;

    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;

    typedef enum logic [1:0] {
        FLT_NONE     = 2'b00,
        FLT_MISALIGN = 2'b01,
        FLT_ILLEGAL  = 2'b10,
        FLT_TIMEOUT  = 2'b11
    } lsu_fault_e;

    // Unsigned sizes only make sense for loads.
    function automatic logic lsu_legal(input logic [2:0] op, input logic iop);
        logic ok;
        ok = (op == LSU_B) || (op == LSU_H) || (op == LSU_W) ||
             (!iop && ((op == LSU_BU) || (op == LSU_HU)));
        return ok;
    endfunction

    // Halfwords need an even address, words a 4-byte aligned one.
    function automatic logic lsu_misaligned(input logic [2:0] op, input logic [1:0] off);
        logic bad;
        bad = ((op[1:0] == 2'b01) && off[0]) ||
              ((op == LSU_W) && (off != 2'b00));
        return bad;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for stores and lane extraction / extension for loads.
module lsu_lane_align
    import rapid_pkg::*;
(
    input  logic [2:0]      i_op,
    input  logic            i_iop,
    input  logic [1:0]      i_off,
    input  logic [XLEN-1:0] i_wdata,
    input  logic [XLEN-1:0] i_rdata,
    output logic [3:0]      o_be,
    output logic [XLEN-1:0] o_wdata,
    output logic [XLEN-1:0] o_rdata
);

    logic [XLEN-1:0] w_shift;

    // Bring the addressed byte/half down to bit 0 before extending.
    assign w_shift = i_rdata >> {i_off, 3'b000};

    // Store replication and byte enables; loads always read the full word.
    always_comb begin
        o_be    = 4'b1111;
        o_wdata = i_wdata;
        if (i_iop) begin
            case (i_op[1:0])
                2'b00: begin
                    o_be    = 4'b0001 << i_off;
                    o_wdata = {4{i_wdata[7:0]}};
                end
                2'b01: begin
                    o_be    = 4'b0011 << i_off;
                    o_wdata = {2{i_wdata[15:0]}};
                end
                default: begin
                    o_be    = 4'b1111;
                    o_wdata = i_wdata;
                end
            endcase
        end
    end

    // Load sign/zero extension by access size.
    always_comb begin
        case (i_op)
            LSU_B:   o_rdata = {{24{w_shift[7]}}, w_shift[7:0]};
            LSU_H:   o_rdata = {{16{w_shift[15]}}, w_shift[15:0]};
            LSU_BU:  o_rdata = {24'd0, w_shift[7:0]};
            LSU_HU:  o_rdata = {16'd0, w_shift[15:0]};
            default: o_rdata = w_shift;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: accepts one memory access at a time from
// execute, runs it on a simple req/ack bus with a timeout, and returns load
// data for writeback. Bad opcodes and misaligned addresses fault at accept.
module lsu_ctrl
    import rapid_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    input  control_mem_s    i_control_signal,
    input  logic [XLEN-1:0] i_addr,
    input  logic [XLEN-1:0] i_wdata,
    output logic            o_bus_req,
    output logic            o_bus_we,
    output logic [XLEN-1:0] o_bus_addr,
    output logic [XLEN-1:0] o_bus_wdata,
    output logic [3:0]      o_bus_be,
    input  logic            i_bus_ack,
    input  logic [XLEN-1:0] i_bus_rdata,
    output logic            o_stall,
    output logic            o_wb_valid,
    output logic [4:0]      o_wb_rd,
    output logic [XLEN-1:0] o_wb_data,
    output logic            o_fault,
    output logic [1:0]      o_fault_cause
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

    lsu_state_e      r_state;
    logic [7:0]      r_cnt;
    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] r_wdata;
    logic [2:0]      r_op;
    logic [4:0]      r_rd;
    logic            r_iop;
    logic [XLEN-1:0] r_rdata;

    logic            w_idle, w_req, w_done;
    logic            w_take, w_illegal, w_misal, w_accept, w_expire;
    logic [3:0]      w_be;
    logic [XLEN-1:0] w_wdata_lane, w_rdata_ext;

    assign w_idle = (r_state == LSU_IDLE);
    assign w_req  = (r_state == LSU_REQ);
    assign w_done = (r_state == LSU_DONE);

    // Reset gates the accept path so every output is low while it is held.
    assign w_take    = w_idle && !i_rst && i_valid && i_control_signal.mem;
    assign w_illegal = w_take && !lsu_legal(i_control_signal.fcs_opcode, i_control_signal.iop);
    assign w_misal   = w_take && !w_illegal &&
                       lsu_misaligned(i_control_signal.fcs_opcode, i_addr[1:0]);
    assign w_accept  = w_take && !w_illegal && !w_misal;
    // Expiry is the last allowed REQ cycle with no ack; an ack there wins.
    assign w_expire  = w_req && !i_bus_ack && (r_cnt == CNT_LAST);

    lsu_lane_align u_align (
        .i_op    (r_op),
        .i_iop   (r_iop),
        .i_off   (r_addr[1:0]),
        .i_wdata (r_wdata),
        .i_rdata (i_bus_rdata),
        .o_be    (w_be),
        .o_wdata (w_wdata_lane),
        .o_rdata (w_rdata_ext)
    );

    // Access FSM with timeout counter and latched request fields.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= LSU_IDLE;
            r_cnt   <= 8'd0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_op    <= 3'd0;
            r_rd    <= 5'd0;
            r_iop   <= 1'b0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                LSU_IDLE: begin
                    if (w_accept) begin
                        r_addr  <= i_addr;
                        r_wdata <= i_wdata;
                        r_op    <= i_control_signal.fcs_opcode;
                        r_rd    <= i_control_signal.rd;
                        r_iop   <= i_control_signal.iop;
                        r_cnt   <= 8'd0;
                        r_state <= LSU_REQ;
                    end
                end
                LSU_REQ: begin
                    if (i_bus_ack) begin
                        r_rdata <= w_rdata_ext;
                        r_state <= LSU_DONE;
                    end else if (w_expire) begin
                        r_state <= LSU_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: r_state <= LSU_IDLE;
            endcase
        end
    end

    // Bus signals come straight from latched fields, so they stay stable in REQ.
    always_comb begin
        o_bus_req   = w_req;
        o_bus_we    = w_req && r_iop;
        o_bus_addr  = w_req ? {r_addr[XLEN-1:2], 2'b00} : '0;
        o_bus_wdata = (w_req && r_iop) ? w_wdata_lane : '0;
        o_bus_be    = w_req ? w_be : 4'b0000;
    end

    // Stall, writeback and fault reporting.
    always_comb begin
        o_stall    = w_req || w_accept;
        o_wb_valid = w_done && !r_iop && (r_rd != 5'd0);
        o_wb_rd    = o_wb_valid ? r_rd : 5'd0;
        o_wb_data  = o_wb_valid ? r_rdata : '0;
        o_fault    = w_illegal || w_misal || w_expire;
        if (w_illegal)     o_fault_cause = FLT_ILLEGAL;
        else if (w_misal)  o_fault_cause = FLT_MISALIGN;
        else if (w_expire) o_fault_cause = FLT_TIMEOUT;
        else               o_fault_cause = FLT_NONE;
    end

endmodule
